// File: rtl/uart_pkg.sv
// Shared UART definitions: supervisor state encoding and bit-timing helper.
package uart_pkg;

   typedef enum logic [1:0] {
      RESET     = 2'd0,
      RUN       = 2'd1,
      WAIT_IDLE = 2'd2,
      PULSE     = 2'd3
   } sup_states_t;

   function automatic int unsigned cycles_per_bit(input int unsigned freq,
                                                  input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module uart_sync2 #(
   parameter logic ResetVal = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta <= ResetVal;
         o_q  <= ResetVal;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_supervisor.sv
// UART receive-path supervisor: framing-error recovery, backpressure gating,
// line-break detection and frame/error statistics.
module uart_rx_supervisor
   import uart_pkg::*;
#(
   parameter int unsigned SystemClockFreq = 50_000_000,
   parameter int unsigned BaudRate        = 115200,
   parameter int unsigned IdleBits        = 10,
   parameter int unsigned BreakBits       = 20,
   parameter int unsigned RstCycles       = 4,
   parameter int unsigned ErrCountWidth   = 8,
   parameter int unsigned FrameCountWidth = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_rx,
   input  logic                       i_rx_error,
   input  logic                       i_rx_fifo_write_en,
   input  logic                       i_fifo_full,
   input  logic                       i_clear_stats,
   output logic                       o_rx_rst_n,
   output logic                       o_rx_fifo_full,
   output logic                       o_busy,
   output logic                       o_recovered,
   output logic                       o_break,
   output logic [ErrCountWidth-1:0]   o_err_count,
   output logic [FrameCountWidth-1:0] o_frame_count
);

   localparam int unsigned CyclesPerBit = cycles_per_bit(SystemClockFreq, BaudRate);
   localparam int unsigned IdleCycles   = IdleBits * CyclesPerBit;
   localparam int unsigned BreakCycles  = BreakBits * CyclesPerBit;
   localparam int unsigned IdleW        = $clog2(IdleCycles + 1);
   localparam int unsigned LowW         = $clog2(BreakCycles + 1);

   localparam logic [IdleW-1:0] IdleLast  = IdleW'(IdleCycles - 1);
   localparam logic [LowW-1:0]  LowLast   = LowW'(BreakCycles - 1);
   localparam logic [3:0]       PulseLast = 4'(RstCycles - 1);

   sup_states_t       curr_state, next_state;
   logic              rx_s;
   logic              err_event;
   logic [IdleW-1:0]  idle_cnt;
   logic [LowW-1:0]   low_cnt;
   logic [3:0]        pulse_cnt;

   uart_sync2 #(.ResetVal(1'b1)) u_rx_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_rx),
      .o_q     (rx_s)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) curr_state <= RESET;
      else          curr_state <= next_state;
   end

   // Errors are only acted on in RUN; the receiver flag is stale elsewhere.
   always_comb begin
      next_state = curr_state;
      err_event  = 1'b0;
      case (curr_state)
         RESET:     next_state = RUN;
         RUN: begin
            if (i_rx_error) begin
               next_state = WAIT_IDLE;
               err_event  = 1'b1;
            end
         end
         WAIT_IDLE: if (rx_s && (idle_cnt == IdleLast)) next_state = PULSE;
         PULSE:     if (pulse_cnt == PulseLast) next_state = RUN;
         default:   next_state = RESET;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idle_cnt  <= '0;
         pulse_cnt <= '0;
      end else begin
         if ((curr_state == WAIT_IDLE) && rx_s && (idle_cnt != IdleLast))
            idle_cnt <= idle_cnt + 1'b1;
         else
            idle_cnt <= '0;
         if ((curr_state == PULSE) && (pulse_cnt != PulseLast))
            pulse_cnt <= pulse_cnt + 1'b1;
         else
            pulse_cnt <= '0;
      end
   end

   // Status flops are loaded from next_state so they track curr_state exactly.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rx_rst_n  <= 1'b0;
         o_busy      <= 1'b0;
         o_recovered <= 1'b0;
      end else begin
         o_rx_rst_n  <= !((next_state == RESET) || (next_state == PULSE));
         o_busy      <= (next_state == WAIT_IDLE) || (next_state == PULSE);
         o_recovered <= (curr_state == PULSE) && (next_state == RUN);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         low_cnt <= '0;
         o_break <= 1'b0;
      end else if (rx_s) begin
         low_cnt <= '0;
         o_break <= 1'b0;
      end else begin
         if (low_cnt != LowLast) low_cnt <= low_cnt + 1'b1;
         if (low_cnt == LowLast) o_break <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_err_count   <= '0;
         o_frame_count <= '0;
      end else if (i_clear_stats) begin
         o_err_count   <= '0;
         o_frame_count <= '0;
      end else begin
         if (err_event && (o_err_count != '1)) o_err_count <= o_err_count + 1'b1;
         if (i_rx_fifo_write_en) o_frame_count <= o_frame_count + 1'b1;
      end
   end

   assign o_rx_fifo_full = i_fifo_full | o_busy | o_break;

endmodule

// File: tb/tb_uart_rx_supervisor.sv
// Directed self-checking bench for uart_rx_supervisor (10 clocks per bit).
module tb_uart_rx_supervisor;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_rx;
   logic       i_rx_error;
   logic       i_rx_fifo_write_en;
   logic       i_fifo_full;
   logic       i_clear_stats;
   logic       o_rx_rst_n;
   logic       o_rx_fifo_full;
   logic       o_busy;
   logic       o_recovered;
   logic       o_break;
   logic [7:0] o_err_count;
   logic [7:0] o_frame_count;

   int n_vec = 0;
   int n_err = 0;

   uart_rx_supervisor #(
      .SystemClockFreq (1_000_000),
      .BaudRate        (100_000),
      .IdleBits        (10),
      .BreakBits       (20),
      .RstCycles       (4),
      .ErrCountWidth   (8),
      .FrameCountWidth (8)
   ) dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_rx               (i_rx),
      .i_rx_error         (i_rx_error),
      .i_rx_fifo_write_en (i_rx_fifo_write_en),
      .i_fifo_full        (i_fifo_full),
      .i_clear_stats      (i_clear_stats),
      .o_rx_rst_n         (o_rx_rst_n),
      .o_rx_fifo_full     (o_rx_fifo_full),
      .o_busy             (o_busy),
      .o_recovered        (o_recovered),
      .o_break            (o_break),
      .o_err_count        (o_err_count),
      .o_frame_count      (o_frame_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   // Walks one recovery from the first WAIT_IDLE sample to the first non-busy one.
   task automatic run_recovery(input int glitch_at, input bit poke_err,
                               output int wait_n, output int pulse_n, output int rec_n);
      wait_n = 0; pulse_n = 0; rec_n = 0;
      for (int c = 0; c < 400; c++) begin
         if (o_busy && o_rx_rst_n) wait_n++;
         else if (o_busy && !o_rx_rst_n) pulse_n++;
         else begin
            rec_n = int'(o_recovered);
            break;
         end
         i_rx = (glitch_at > 0 && pulse_n == 0 && wait_n == glitch_at + 1) ? 1'b0 : 1'b1;
         i_rx_error = poke_err && ((pulse_n == 0 && wait_n == 10) || pulse_n == 2);
         tick();
      end
      i_rx = 1'b1;
      i_rx_error = 1'b0;
   endtask

   initial begin
      int wait_n, pulse_n, rec_n, first_brk, rises;
      logic prev_busy;

      i_rst_n = 1'b0; i_rx = 1'b1; i_rx_error = 1'b0; i_rx_fifo_write_en = 1'b0;
      i_fifo_full = 1'b0; i_clear_stats = 1'b0;
      @(negedge i_clk);
      tick();

      check_val("rst_rx_rst_n", o_rx_rst_n, 0);
      check_val("rst_busy", o_busy, 0);
      check_val("rst_recovered", o_recovered, 0);
      check_val("rst_break", o_break, 0);
      check_val("rst_err_count", o_err_count, 0);
      check_val("rst_frame_count", o_frame_count, 0);
      i_fifo_full = 1'b1; #1;
      check_val("rst_fifo_full_follow", o_rx_fifo_full, 1);
      i_fifo_full = 1'b0; #1;
      check_val("rst_fifo_full_low", o_rx_fifo_full, 0);

      i_rst_n = 1'b1;
      tick(); tick();
      check_val("run_rx_rst_n", o_rx_rst_n, 1);
      check_val("run_busy", o_busy, 0);

      // Backpressure in RUN is pass-through
      i_fifo_full = 1'b1; #1;
      check_val("bp_run_hi", o_rx_fifo_full, 1);
      i_fifo_full = 1'b0; #1;
      check_val("bp_run_lo", o_rx_fifo_full, 0);

      // Clean recovery
      i_rx_error = 1'b1;
      tick();
      i_rx_error = 1'b0;
      check_val("rec_busy", o_busy, 1);
      check_val("rec_err_count", o_err_count, 1);
      check_val("bp_wait_idle", o_rx_fifo_full, 1);
      run_recovery(0, 1'b0, wait_n, pulse_n, rec_n);
      check_val("rec_wait_cycles", wait_n, 100);
      check_val("rec_pulse_cycles", pulse_n, 4);
      check_val("rec_recovered", rec_n, 1);
      tick();
      check_val("rec_recovered_drop", o_recovered, 0);
      check_val("rec_busy_drop", o_busy, 0);

      // Glitch at idle count 60 plus stale errors in WAIT_IDLE and PULSE
      i_rx_error = 1'b1;
      tick();
      i_rx_error = 1'b0;
      run_recovery(60, 1'b1, wait_n, pulse_n, rec_n);
      check_val("glitch_wait_cycles", wait_n, 163);
      check_val("glitch_pulse_cycles", pulse_n, 4);
      check_val("glitch_recovered", rec_n, 1);
      check_val("glitch_err_count", o_err_count, 2);
      tick();

      // Line break
      i_rx = 1'b0;
      first_brk = 0;
      for (int k = 1; k <= 250; k++) begin
         tick();
         if (o_break && first_brk == 0) begin
            first_brk = k;
            check_val("brk_fifo_full", o_rx_fifo_full, 1);
         end
      end
      check_val("brk_first_cycle", first_brk, 202);
      check_val("brk_busy", o_busy, 0);
      i_rx = 1'b1;
      tick(); tick();
      check_val("brk_hold_2", o_break, 1);
      tick();
      check_val("brk_clear_3", o_break, 0);

      // Counters
      i_clear_stats = 1'b1;
      tick();
      i_clear_stats = 1'b0;
      check_val("clr_err", o_err_count, 0);
      check_val("clr_frame", o_frame_count, 0);

      i_rx_fifo_write_en = 1'b1;
      for (int k = 0; k < 300; k++) tick();
      i_rx_fifo_write_en = 1'b0;
      check_val("frame_wrap_300", o_frame_count, 44);

      i_rx_error = 1'b1;
      rises = 0;
      prev_busy = o_busy;
      for (int c = 0; c < 40000 && rises < 260; c++) begin
         tick();
         if (o_busy && !prev_busy) begin
            rises++;
            if (rises == 254) check_val("err_254", o_err_count, 254);
         end
         prev_busy = o_busy;
      end
      i_rx_error = 1'b0;
      check_val("err_rises", rises, 260);
      check_val("err_saturate", o_err_count, 255);
      check_val("err_frame_kept", o_frame_count, 44);
      for (int c = 0; c < 300 && o_busy; c++) tick();
      tick();

      i_clear_stats = 1'b1; i_rx_fifo_write_en = 1'b1;
      tick();
      i_clear_stats = 1'b0; i_rx_fifo_write_en = 1'b0;
      check_val("clr_win_err", o_err_count, 0);
      check_val("clr_win_frame", o_frame_count, 0);

      // Reset during PULSE
      i_rx_fifo_write_en = 1'b1;
      i_rx_error = 1'b1;
      tick();
      i_rx_fifo_write_en = 1'b0;
      i_rx_error = 1'b0;
      for (int c = 0; c < 200 && !(o_busy && !o_rx_rst_n); c++) tick();
      check_val("mid_in_pulse", o_busy && !o_rx_rst_n, 1);
      check_val("mid_err_before", o_err_count, 1);
      #2 i_rst_n = 1'b0;
      #1;
      check_val("mid_rx_rst_n", o_rx_rst_n, 0);
      check_val("mid_busy", o_busy, 0);
      check_val("mid_recovered", o_recovered, 0);
      check_val("mid_break", o_break, 0);
      check_val("mid_err", o_err_count, 0);
      check_val("mid_frame", o_frame_count, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick(); tick();
      check_val("mid_run_rx_rst_n", o_rx_rst_n, 1);
      check_val("mid_run_busy", o_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
